serial_add_sched: RTL and testbench

//   Scheduler/sequencer for a shared bit-serial adder. Two requesters present

---
 rtl/serial_add_sched.sv | 207 ++++++++++++++++++++
 tb/tb_serial_add_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sched.sv
// ---------------------------------------------------------------------------
// serial_add_sched
//   Round-robin scheduler and sequencer for a shared bit-serial adder.
//   Two requesters present WIDTH-bit operand pairs. The winner's operands are
//   latched and added LSB-first, one bit per clock, through a single full-adder
//   cell and a carry flop. Sum/Cout are published together with a one-cycle
//   done strobe tagged by the granted requester id.
//
// Ports
//   clk_i      in   1      rising-edge clock
//   rst_i      in   1      asynchronous, active-high reset
//   req0_i     in   1      requester 0 request (level, held until its done)
//   a0_i       in   WIDTH  requester 0 operand A
//   b0_i       in   WIDTH  requester 0 operand B
//   req1_i     in   1      requester 1 request (level, held until its done)
//   a1_i       in   WIDTH  requester 1 operand A
//   b1_i       in   WIDTH  requester 1 operand B
//   busy_o     out  1      high while a job is in ADD or DONE
//   gnt_id_o   out  1      requester currently/last served
//   done_o     out  1      one-cycle strobe, sum_o/cout_o valid for gnt_id_o
//   sum_o      out  WIDTH  (A+B) mod 2^WIDTH of the last completed job
//   cout_o     out  1      carry out of the last completed job
//
// States
//   S_IDLE | waiting for a request; arbitrates and latches operands
//   S_ADD  | one sum bit per clock, exactly WIDTH cycles
//   S_DONE | result published, done_o high for this single cycle
// ---------------------------------------------------------------------------
module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    output logic             busy_o,
    output logic             gnt_id_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             gnt_q, gnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             any_req;
    logic             winner;
    logic             last_bit;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] acc_shifted;

    assign any_req  = req0_i | req1_i;
    // On a tie the requester not served last wins; otherwise the sole requester.
    assign winner   = (req0_i & req1_i) ? ~last_q : req1_i;
    assign last_bit = (cnt_q == CNT_LAST);

    // Full-adder cell shared by every bit position.
    assign s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign c_next = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
    assign acc_shifted = {s_bit, acc_q[WIDTH-1:1]};

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (last_bit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            S_ADD: begin
                busy_o = 1'b1;
            end
            S_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
                done_o = 1'b0;
            end
        endcase
    end

    assign gnt_id_o = gnt_q;
    assign sum_o    = sum_q;
    assign cout_o   = cout_q;

    // ----------------------------------------------------------------- datapath
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    a_sh_d  = winner ? a1_i : a0_i;
                    b_sh_d  = winner ? b1_i : b0_i;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    gnt_d   = winner;
                    last_d  = winner;
                end
            end
            S_ADD: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                acc_d   = acc_shifted;
                carry_d = c_next;
                cnt_d   = cnt_q + CW'(1);
                // Publish only the fully formed word so sum_o never shows partials.
                if (last_bit) begin
                    sum_d  = acc_shifted;
                    cout_d = c_next;
                end
            end
            default: begin
                a_sh_d = a_sh_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
module tb_serial_add_sched;

    logic       clk_i;
    logic       rst_i;
    logic       req0_i;
    logic [7:0] a0_i;
    logic [7:0] b0_i;
    logic       req1_i;
    logic [7:0] a1_i;
    logic [7:0] b1_i;
    logic       busy_o;
    logic       gnt_id_o;
    logic       done_o;
    logic [7:0] sum_o;
    logic       cout_o;

    serial_add_sched #(.WIDTH(8)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req0_i   (req0_i),
        .a0_i     (a0_i),
        .b0_i     (b0_i),
        .req1_i   (req1_i),
        .a1_i     (a1_i),
        .b1_i     (b1_i),
        .busy_o   (busy_o),
        .gnt_id_o (gnt_id_o),
        .done_o   (done_o),
        .sum_o    (sum_o),
        .cout_o   (cout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        bit         c;
    } vec_t;

    typedef struct {
        bit         id;
        logic [7:0] s;
        bit         c;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input bit id, input logic [7:0] s, input bit c);
        exp_t e;
        e.id = id;
        e.s  = s;
        e.c  = c;
        sb.push_back(e);
    endtask

    // Waits (bounded) for done_o at negedges, then pops and compares the result.
    // Called at a negedge; returns at the negedge where done_o was seen.
    task automatic wait_done(input string tag, input bit scramble,
                             output int edges, output int busy_n);
        bit   seen;
        exp_t e;
        seen   = 1'b0;
        edges  = 0;
        busy_n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_i);
            edges++;
            if (busy_o) busy_n++;
            if (done_o) seen = 1'b1;
            if (scramble && edges == 3) begin
                a0_i = 8'($urandom);
                b0_i = 8'($urandom);
                a1_i = 8'($urandom);
                b1_i = 8'($urandom);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done expected=done", tag);
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_done actual=done expected=none", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_gnt"}, 32'(gnt_id_o), 32'(e.id));
            chk({tag, "_sum"}, 32'(sum_o), 32'(e.s));
            chk({tag, "_cout"}, 32'(cout_o), 32'(e.c));
        end
    endtask

    // One complete single-requester job, including the deassert handshake.
    task automatic do_job(input string tag, input bit id, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] s, input bit c,
                          input bit scramble);
        int edges;
        int busy_n;
        if (id) begin
            a1_i = a; b1_i = b; req1_i = 1'b1;
        end else begin
            a0_i = a; b0_i = b; req0_i = 1'b1;
        end
        push(id, s, c);
        wait_done(tag, scramble, edges, busy_n);
        chk({tag, "_latency"}, 32'(edges), 32'd9);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd9);
        @(posedge clk_i);
        #1;
        if (id) req1_i = 1'b0; else req0_i = 1'b0;
        @(negedge clk_i);
        chk({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
        chk({tag, "_busy_fall"}, 32'(busy_o), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int          edges;
        int          busy_n;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [8:0]  rsum;

        checks = 0;
        errors = 0;
        vecs[0] = '{id: 1'b0, a: 8'h00, b: 8'hFF, s: 8'hFF, c: 1'b0};
        vecs[1] = '{id: 1'b1, a: 8'hB7, b: 8'h0D, s: 8'hC4, c: 1'b0};
        vecs[2] = '{id: 1'b0, a: 8'h01, b: 8'h80, s: 8'h81, c: 1'b0};
        vecs[3] = '{id: 1'b0, a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
        vecs[4] = '{id: 1'b1, a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1};
        vecs[5] = '{id: 1'b1, a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1};
        vecs[6] = '{id: 1'b0, a: 8'h55, b: 8'hAA, s: 8'hFF, c: 1'b0};
        vecs[7] = '{id: 1'b0, a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0};

        rst_i  = 1'b1;
        req0_i = 1'b0;
        req1_i = 1'b0;
        a0_i   = '0;
        b0_i   = '0;
        a1_i   = '0;
        b1_i   = '0;
        #1;
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_sum", 32'(sum_o), 32'd0);
        chk("reset_cout", 32'(cout_o), 32'd0);
        chk("reset_gnt", 32'(gnt_id_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle_no_req_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_job($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b,
                   vecs[i].s, vecs[i].c, 1'b0);
        end

        for (int i = 0; i < 4; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rsum = {1'b0, ra} + {1'b0, rb};
            do_job($sformatf("rnd%0d", i), bit'(i % 2), ra, rb, rsum[7:0], rsum[8], 1'b0);
        end

        // Operands scribbled during ADD must not affect the result.
        do_job("scramble", 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b1);
        repeat (3) @(negedge clk_i);
        chk("sum_hold", 32'(sum_o), 32'h4B);
        chk("gnt_hold", 32'(gnt_id_o), 32'd0);

        // Tie right after reset: requester 0 wins first.
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        a0_i = 8'hB7; b0_i = 8'h0D;
        a1_i = 8'h42; b1_i = 8'h21;
        req0_i = 1'b1;
        req1_i = 1'b1;
        push(1'b0, 8'hC4, 1'b0);
        push(1'b1, 8'h63, 1'b0);
        wait_done("tie_first", 1'b0, edges, busy_n);
        chk("tie_first_latency", 32'(edges), 32'd9);
        @(posedge clk_i);
        #1;
        req0_i = 1'b0;
        @(negedge clk_i);
        wait_done("tie_second", 1'b0, edges, busy_n);
        chk("tie_spacing", 32'(edges + 1), 32'd10);
        @(posedge clk_i);
        #1;
        req1_i = 1'b0;
        @(negedge clk_i);

        // Both held continuously: service alternates 0,1,0,1.
        req0_i = 1'b1;
        req1_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(1'b0, 8'hC4, 1'b0);
            else            push(1'b1, 8'h63, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            wait_done($sformatf("alt%0d", i), 1'b0, edges, busy_n);
        end
        @(posedge clk_i);
        #1;
        req0_i = 1'b0;
        req1_i = 1'b0;
        @(negedge clk_i);

        // Reset in the 3rd ADD cycle aborts the job with no done.
        a0_i   = 8'h12;
        b0_i   = 8'h34;
        req0_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_sum", 32'(sum_o), 32'd0);
        chk("abort_cout", 32'(cout_o), 32'd0);
        chk("abort_gnt", 32'(gnt_id_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("abort_no_done", 32'(done_o), 32'd0);
        end
        rst_i = 1'b0;
        do_job("restart", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
